// File: rtl/dot11_tx_bit_src_pkg.sv
// dot11_tx_bit_src_pkg
// Shared constants for the 802.11a/g legacy transmit bit source:
//   - legacy rate codes and the rate -> N_DBPS lookup
//   - FSM state encoding
//   - CRC-32 polynomial/init value and the default scrambler seed
package dot11_tx_bit_src_pkg;

  // Legacy rate codes as carried in the SIGNAL field, R1 in bit 0
  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SIGNAL  = 3'd1;
  localparam logic [2:0] ST_SERVICE = 3'd2;
  localparam logic [2:0] ST_PSDU    = 3'd3;
  localparam logic [2:0] ST_FCS     = 3'd4;
  localparam logic [2:0] ST_TAIL    = 3'd5;
  localparam logic [2:0] ST_PAD     = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  // Reflected CRC-32 and the scrambler state used when a zero seed is given
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [6:0]  DEFAULT_SEED = 7'b1011101;

  // Shortest legal PSDU: one payload byte plus the 4-byte FCS
  localparam logic [11:0] MIN_LEN = 12'd5;

  // Data bits per OFDM symbol for each legal rate; 0 marks an illegal code
  function automatic logic [7:0] rateToNdbps(input logic [3:0] rate);
    logic [7:0] ndbps;
    case (rate)
      RATE_6M:  ndbps = 8'd24;
      RATE_9M:  ndbps = 8'd36;
      RATE_12M: ndbps = 8'd48;
      RATE_18M: ndbps = 8'd72;
      RATE_24M: ndbps = 8'd96;
      RATE_36M: ndbps = 8'd144;
      RATE_48M: ndbps = 8'd192;
      RATE_54M: ndbps = 8'd216;
      default:  ndbps = 8'd0;
    endcase
    return ndbps;
  endfunction

endpackage

// File: rtl/dot11_tx_bit_src_crc32_bit.sv
// crc32_bit
// One-bit step of the reflected CRC-32 (LSB-first shift register).
//   i_crc : current CRC register
//   i_bit : payload bit entering the CRC
//   o_crc : CRC register after absorbing i_bit
module crc32_bit
  import dot11_tx_bit_src_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic        i_bit,
  output logic [31:0] o_crc
);

  logic w_fb;

  // Reflected form: shift right, fold the polynomial in when the bit leaving
  // the register disagrees with the incoming data bit
  assign w_fb  = i_crc[0] ^ i_bit;
  assign o_crc = {1'b0, i_crc[31:1]} ^ (w_fb ? CRC_POLY : 32'h0000_0000);

endmodule

// File: rtl/dot11_tx_bit_src.sv
// dot11_tx_bit_src
// Produces the serial legacy 802.11a/g bit stream for one packet:
// SIGNAL (24 bits, unscrambled), then DATA = SERVICE, PSDU payload, FCS,
// TAIL and PAD, scrambled except for the tail.
// Ports:
//   clk, rstn                        clock, async active-low reset
//   tx_start, tx_rate, tx_len,       packet request (sampled in IDLE)
//   scram_seed
//   byte_in, byte_in_valid,          payload byte stream (valid/ready)
//   byte_in_ready
//   bit_out, bit_out_valid,          output bit stream (valid/ready)
//   bit_out_ready
//   bit_is_signal, sym_last          per-bit side information
//   n_ofdm_sym                       DATA symbols completed so far
//   busy, pkt_done, param_err        status
module dot11_tx_bit_src
  import dot11_tx_bit_src_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_start,
  input  logic [3:0]  tx_rate,
  input  logic [11:0] tx_len,
  input  logic [6:0]  scram_seed,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic        bit_out,
  output logic        bit_out_valid,
  input  logic        bit_out_ready,
  output logic        bit_is_signal,
  output logic        sym_last,
  output logic [14:0] n_ofdm_sym,
  output logic        busy,
  output logic        pkt_done,
  output logic        param_err
);

  logic [2:0]  r_state;
  logic [3:0]  r_rate;
  logic [11:0] r_len;
  logic [7:0]  r_ndbps;
  logic [6:0]  r_scr;
  logic [31:0] r_crc;
  logic [14:0] r_cnt;
  logic [7:0]  r_symCnt;
  logic [14:0] r_nSym;
  logic [7:0]  r_shift;
  logic [3:0]  r_shCnt;
  logic        r_paramErr;

  logic [7:0]  w_ndbpsIn;
  logic        w_startOk;
  logic        w_startBad;
  logic [23:0] w_sigVec;
  logic [14:0] w_psduBits;
  logic        w_scrFb;
  logic        w_symEnd;
  logic        w_valid;
  logic        w_rawBit;
  logic        w_scrOn;
  logic        w_isData;
  logic        w_lastInState;
  logic [2:0]  w_nextState;
  logic        w_xfer;
  logic        w_byteAcc;
  logic [31:0] w_crcNext;

  // Start qualification happens only in IDLE; anything else ignores tx_start
  assign w_ndbpsIn  = rateToNdbps(tx_rate);
  assign w_startOk  = tx_start && (r_state == ST_IDLE) &&
                      (w_ndbpsIn != 8'd0) && (tx_len >= MIN_LEN);
  assign w_startBad = tx_start && (r_state == ST_IDLE) &&
                      ((w_ndbpsIn == 8'd0) || (tx_len < MIN_LEN));

  // SIGNAL field in emission order (bit 0 goes out first)
  assign w_sigVec   = {6'b000000, ^{r_len, r_rate}, r_len, 1'b0, r_rate};
  assign w_psduBits = {r_len - 12'd4, 3'b000};
  assign w_scrFb    = r_scr[6] ^ r_scr[3];
  assign w_symEnd   = (r_symCnt == r_ndbps - 8'd1);

  // Per-state bit source, scrambling enable and end-of-state detection
  always_comb begin
    w_valid       = 1'b0;
    w_rawBit      = 1'b0;
    w_scrOn       = 1'b0;
    w_isData      = 1'b0;
    w_lastInState = 1'b0;
    case (r_state)
      ST_SIGNAL: begin
        w_valid       = 1'b1;
        w_rawBit      = w_sigVec[r_cnt[4:0]];
        w_lastInState = (r_cnt == 15'd23);
      end
      ST_SERVICE: begin
        w_valid       = 1'b1;
        w_scrOn       = 1'b1;
        w_isData      = 1'b1;
        w_lastInState = (r_cnt == 15'd15);
      end
      ST_PSDU: begin
        w_valid       = (r_shCnt != 4'd0);
        w_rawBit      = r_shift[0];
        w_scrOn       = 1'b1;
        w_isData      = 1'b1;
        w_lastInState = (r_cnt == w_psduBits - 15'd1);
      end
      ST_FCS: begin
        w_valid       = 1'b1;
        w_rawBit      = ~r_crc[r_cnt[4:0]];
        w_scrOn       = 1'b1;
        w_isData      = 1'b1;
        w_lastInState = (r_cnt == 15'd31);
      end
      ST_TAIL: begin
        w_valid       = 1'b1;
        w_isData      = 1'b1;
        w_lastInState = (r_cnt == 15'd5);
      end
      ST_PAD: begin
        w_valid       = 1'b1;
        w_scrOn       = 1'b1;
        w_isData      = 1'b1;
        w_lastInState = w_symEnd;
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  // Successor of each emitting state; PAD is skipped when the tail already
  // closes a symbol
  always_comb begin
    w_nextState = ST_IDLE;
    case (r_state)
      ST_SIGNAL:  w_nextState = ST_SERVICE;
      ST_SERVICE: w_nextState = ST_PSDU;
      ST_PSDU:    w_nextState = ST_FCS;
      ST_FCS:     w_nextState = ST_TAIL;
      ST_TAIL:    w_nextState = w_symEnd ? ST_DONE : ST_PAD;
      ST_PAD:     w_nextState = ST_DONE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  assign w_xfer        = w_valid && bit_out_ready;
  assign byte_in_ready = (r_state == ST_PSDU) && (r_shCnt == 4'd0);
  assign w_byteAcc     = byte_in_ready && byte_in_valid;

  assign bit_out       = w_rawBit ^ (w_scrOn & w_scrFb);
  assign bit_out_valid = w_valid;
  assign bit_is_signal = (r_state == ST_SIGNAL);
  assign sym_last      = w_valid && (bit_is_signal ? (r_cnt == 15'd23)
                                                   : (w_isData && w_symEnd));
  assign n_ofdm_sym    = r_nSym;
  assign busy          = (r_state != ST_IDLE);
  assign pkt_done      = (r_state == ST_DONE);
  assign param_err     = r_paramErr;

  crc32_bit u_crc (
    .i_crc (r_crc),
    .i_bit (r_shift[0]),
    .o_crc (w_crcNext)
  );

  // Main FSM and the in-state bit counter; every emitting state leaves on
  // the transfer of its last bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_startOk) begin
            r_state <= ST_SIGNAL;
            r_cnt   <= '0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          if (w_xfer) begin
            if (w_lastInState) begin
              r_state <= w_nextState;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 15'd1;
            end
          end
        end
      endcase
    end
  end

  // Packet parameters are captured on an accepted start; a rejected start
  // only raises a one-cycle error pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rate     <= '0;
      r_len      <= '0;
      r_ndbps    <= '0;
      r_paramErr <= 1'b0;
    end else begin
      r_paramErr <= w_startBad;
      if (w_startOk) begin
        r_rate  <= tx_rate;
        r_len   <= tx_len;
        r_ndbps <= w_ndbpsIn;
      end
    end
  end

  // Scrambler steps on every transferred DATA bit (tail included, even
  // though tail bits leave unscrambled); CRC absorbs payload bits only
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scr <= '0;
      r_crc <= '0;
    end else if (w_startOk) begin
      r_scr <= (scram_seed == 7'd0) ? DEFAULT_SEED : scram_seed;
      r_crc <= CRC_INIT;
    end else if (w_xfer) begin
      if (w_isData) begin
        r_scr <= {r_scr[5:0], w_scrFb};
      end
      if (r_state == ST_PSDU) begin
        r_crc <= w_crcNext;
      end
    end
  end

  // Byte-to-bit shifter: refilled only once empty, drained LSB first
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
      r_shCnt <= '0;
    end else if (w_byteAcc) begin
      r_shift <= byte_in;
      r_shCnt <= 4'd8;
    end else if (w_xfer && (r_state == ST_PSDU)) begin
      r_shift <= {1'b0, r_shift[7:1]};
      r_shCnt <= r_shCnt - 4'd1;
    end
  end

  // Per-symbol DATA bit counter and completed-symbol count; the count is
  // left untouched after DONE until the next accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_symCnt <= '0;
      r_nSym   <= '0;
    end else if (w_startOk) begin
      r_symCnt <= '0;
      r_nSym   <= '0;
    end else if (w_xfer && w_isData) begin
      if (w_symEnd) begin
        r_symCnt <= '0;
        r_nSym   <= r_nSym + 15'd1;
      end else begin
        r_symCnt <= r_symCnt + 8'd1;
      end
    end
  end

endmodule
